ch_readout_serializer: RTL and testbench

Per-channel readout transmitter. It captures the bank counter values, the trigger count and the active sampling mode when the channel controller enters `STATE_READOUT`. It then shifts them out MSB-first as a fixed-length serial frame, one bit per `shift_en` strobe from the SPI slave. It sits between the channel state machine and the SPI output mux, and is the sending end of the readout path that the SPI master decodes.

---
 rtl/ch_readout_serializer_if.sv | 26 ++
 rtl/ch_readout_serializer.sv | 111 +++++++++++
 tb/tb_ch_readout_serializer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ch_readout_serializer_if.sv
// Readout bus between the channel controller / SPI slave side and the serializer.
// master drives capture data and shift strobes; slave returns the serial stream.
interface ch_readout_serializer_if #(
  parameter int CNT_W  = 8,
  parameter int N_CNT  = 5,
  parameter int TRIG_W = 8
);
  logic [3:0]             state;
  logic [1:0]             smode;
  logic [N_CNT*CNT_W-1:0] cnt_flat;
  logic [TRIG_W-1:0]      trig_cnt;
  logic                   shift_en;
  logic                   sdo;
  logic                   busy;
  logic                   done;

  modport master (
    output state, smode, cnt_flat, trig_cnt, shift_en,
    input  sdo, busy, done
  );

  modport slave (
    input  state, smode, cnt_flat, trig_cnt, shift_en,
    output sdo, busy, done
  );
endinterface

// File: rtl/ch_readout_serializer.sv
// Per-channel readout transmitter: snapshots counters on READOUT entry and shifts an MSB-first frame.
// Optional trailing even-parity bit enabled by defining READOUT_PARITY_EN.
module ch_readout_serializer #(
  parameter int CNT_W  = 8,
  parameter int N_CNT  = 5,
  parameter int TRIG_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  ch_readout_serializer_if.slave bus
);

  localparam logic [3:0] STATE_INIT    = 4'd0;
  localparam logic [3:0] STATE_READOUT = 4'd10;

  localparam int DATA_W = 4 + N_CNT * CNT_W + TRIG_W;
`ifdef READOUT_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} fsm_t;

  fsm_t                 fsm_reg;
  logic [3:0]           state_q_reg;
  logic [FRAME_LEN-1:0] shreg_reg;
  logic [CW-1:0]        bit_cnt_reg;
  logic                 sdo_reg;
  logic                 busy_reg;
  logic                 done_reg;

  // Counter A travels first, so reorder the flat bus with bank A in the top slice.
  logic [N_CNT*CNT_W-1:0] cnt_msbf;
  genvar gi;
  generate
    for (gi = 0; gi < N_CNT; gi++) begin : g_cnt_order
      assign cnt_msbf[(N_CNT-1-gi)*CNT_W +: CNT_W] = bus.cnt_flat[gi*CNT_W +: CNT_W];
    end
  endgenerate

  logic [DATA_W-1:0]    frame_data;
  logic [FRAME_LEN-1:0] frame_load;
  logic                 load_edge;

  assign frame_data = {2'b10, bus.smode, cnt_msbf, bus.trig_cnt};
`ifdef READOUT_PARITY_EN
  assign frame_load = {frame_data, ^frame_data};
`else
  assign frame_load = frame_data;
`endif
  assign load_edge = (state_q_reg != STATE_READOUT) && (bus.state == STATE_READOUT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_reg     <= IDLE;
      state_q_reg <= STATE_INIT;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      sdo_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_q_reg <= bus.state;
      done_reg    <= 1'b0;
      // A new READOUT entry always wins: it restarts the frame and swallows any strobe.
      if (load_edge) begin
        fsm_reg     <= SHIFT;
        shreg_reg   <= frame_load;
        bit_cnt_reg <= '0;
        sdo_reg     <= frame_load[FRAME_LEN-1];
        busy_reg    <= 1'b1;
      end else begin
        case (fsm_reg)
          SHIFT: begin
            if (bus.state == STATE_INIT) begin
              fsm_reg     <= IDLE;
              shreg_reg   <= '0;
              bit_cnt_reg <= '0;
              sdo_reg     <= 1'b0;
              busy_reg    <= 1'b0;
            end else if (bus.shift_en) begin
              shreg_reg   <= {shreg_reg[FRAME_LEN-2:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + CW'(1);
              if (bit_cnt_reg == CW'(FRAME_LEN - 1)) begin
                fsm_reg  <= FINISH;
                sdo_reg  <= 1'b0;
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
              end else begin
                sdo_reg <= shreg_reg[FRAME_LEN-2];
              end
            end
          end
          FINISH: begin
            fsm_reg <= IDLE;
          end
          default: begin
            fsm_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sdo  = sdo_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_ch_readout_serializer.sv
// Directed + randomized bench for ch_readout_serializer against a bit-queue frame model.
// Define READOUT_PARITY_EN for both bench and RTL to cover the parity build.
module tb_ch_readout_serializer;

  logic clk;
  logic rstn;

  ch_readout_serializer_if #(.CNT_W(8), .N_CNT(5), .TRIG_W(8)) bus ();

  ch_readout_serializer dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pos   = 0;

  logic [1:0] m_smode;
  logic [7:0] m_cnt [5];
  logic [7:0] m_trig;
  bit         exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: sync, mode, counters A..E, trigger count, each MSB first, then optional parity.
  task automatic build_frame();
    bit p;
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(m_smode[1]);
    exp_q.push_back(m_smode[0]);
    for (int c = 0; c < 5; c++)
      for (int b = 7; b >= 0; b--) exp_q.push_back(m_cnt[c][b]);
    for (int b = 7; b >= 0; b--) exp_q.push_back(m_trig[b]);
`ifdef READOUT_PARITY_EN
    p = 1'b0;
    foreach (exp_q[i]) p ^= exp_q[i];
    exp_q.push_back(p);
`endif
    bus.smode    = m_smode;
    bus.cnt_flat = {m_cnt[4], m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
    bus.trig_cnt = m_trig;
    pos = 0;
  endtask

  task automatic randomize_data();
    m_smode = 2'($urandom_range(3, 0));
    for (int c = 0; c < 5; c++) m_cnt[c] = 8'($urandom);
    m_trig = 8'($urandom);
  endtask

  task automatic load_frame(input bit collide, input string tag);
    build_frame();
    bus.state    = 4'd10;
    bus.shift_en = collide;
    tick();
    bus.shift_en = 1'b0;
    check({tag, "_load_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_load_sdo"},  32'(bus.sdo),  32'(exp_q[0]));
    check({tag, "_load_done"}, 32'(bus.done), 32'd0);
  endtask

  task automatic shift_bits(input int n, input int max_gap, input string tag);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gap; g++) begin
        bus.shift_en = 1'b0;
        tick();
        check({tag, "_hold_sdo"}, 32'(bus.sdo), 32'(exp_q[pos]));
      end
      bus.shift_en = 1'b1;
      tick();
      bus.shift_en = 1'b0;
      pos++;
      if (pos < exp_q.size()) begin
        check({tag, "_sdo"},  32'(bus.sdo),  32'(exp_q[pos]));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
      end else begin
        check({tag, "_end_sdo"},  32'(bus.sdo),  32'd0);
        check({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_end_done"}, 32'(bus.done), 32'd1);
        tick();
        check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sdo"},  32'(bus.sdo),  32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    rstn         = 1'b0;
    bus.state    = 4'd0;
    bus.smode    = 2'b00;
    bus.cnt_flat = '0;
    bus.trig_cnt = '0;
    bus.shift_en = 1'b0;
    #12;
    check_quiet("reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    check_quiet("post_reset");

    // Basic frame, back-to-back strobes
    bus.state = 4'd1;
    tick();
    m_smode = 2'b11;
    m_cnt[0] = 8'h01; m_cnt[1] = 8'h80; m_cnt[2] = 8'hFF; m_cnt[3] = 8'h00; m_cnt[4] = 8'h5A;
    m_trig = 8'hC3;
    load_frame(1'b0, "basic");
    shift_bits(exp_q.size(), 0, "basic");

    // Dwell in READOUT: no reload
    for (int i = 0; i < 5; i++) begin
      bus.shift_en = 1'b1;
      tick();
      bus.shift_en = 1'b0;
      tick();
      check_quiet("dwell");
    end
    bus.state = 4'd1;
    tick();
    load_frame(1'b0, "reentry");
    shift_bits(exp_q.size(), 2, "reentry");

    // Load edge and strobe in the same cycle
    bus.state = 4'd1;
    tick();
    randomize_data();
    load_frame(1'b1, "collide");
    shift_bits(exp_q.size(), 0, "collide");

    // Abort via STATE_INIT after 20 bits
    bus.state = 4'd1;
    tick();
    randomize_data();
    load_frame(1'b0, "abort");
    shift_bits(20, 1, "abort");
    bus.state = 4'd0;
    tick();
    check_quiet("abort_now");
    tick();
    check_quiet("abort_after");
    load_frame(1'b0, "restart");
    shift_bits(exp_q.size(), 1, "restart");

    // Re-entry of READOUT mid-frame discards the old frame; other states keep shifting
    bus.state = 4'd1;
    tick();
    randomize_data();
    load_frame(1'b0, "midreload_a");
    shift_bits(10, 1, "midreload_a");
    bus.state = 4'd4;
    shift_bits(5, 1, "midreload_other");
    randomize_data();
    load_frame(1'b0, "midreload_b");
    shift_bits(exp_q.size(), 1, "midreload_b");

    // Asynchronous reset mid-frame, then strobes in a non-readout state
    bus.state = 4'd1;
    tick();
    randomize_data();
    load_frame(1'b0, "rst_mid");
    shift_bits(7, 0, "rst_mid");
    #2 rstn = 1'b0;
    #1;
    check_quiet("rst_async");
    bus.state = 4'd5;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.shift_en = 1'b1;
      tick();
      bus.shift_en = 1'b0;
      check_quiet("stopped");
    end

    // Randomized frames with random strobe spacing
    for (int f = 0; f < 4; f++) begin
      bus.state = 4'(1 + $urandom_range(8, 0));
      tick();
      randomize_data();
      load_frame(1'b0, "rand");
      shift_bits(exp_q.size(), 3, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
